ext_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle immediate extender. One unit covers the decode-stage immediate forms (zero, sign, load-upper, branch-offset) and the writeback-stage load-data forms (lb/lbu/lh/lhu).
- Results are registered behind a valid/ready handshake with a 2-entry skid buffer, so a stalled pipeline stage backpressures without losing data.
- Placed between D/E stages (immediate path) and M/W stages (load path) of the pipelined CPU.

---
 rtl/ext_pkg.sv | 10 +
 rtl/ext_pipe_if.sv | 25 ++
 rtl/ext_comb.sv | 39 +++
 rtl/ext_pipe.sv | 60 ++++++
 tb/tb_ext_pipe.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/ext_pkg.sv
// ext_pkg: extension mode encoding and width helpers shared by the extender and decode logic.
package ext_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BOFS, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU
  } ext_op_e;
  function automatic int addr_w(int out_w);
    return $clog2(out_w / 8);
  endfunction
endpackage

// File: rtl/ext_pipe_if.sv
// ext_pipe_if: input beat and result handshake bundle for the extender pipe.
interface ext_pipe_if #(
  parameter int OUT_W = 32,
  parameter int OP_W  = ext_pkg::OP_W
);
  localparam int AW = ext_pkg::addr_w(OUT_W);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  in_op;
  logic [OUT_W-1:0] in_data;
  logic [AW-1:0]    in_addr_lo;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  modport master (
    output flush, in_valid, in_op, in_data, in_addr_lo, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );
  modport slave (
    input  flush, in_valid, in_op, in_data, in_addr_lo, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/ext_comb.sv
// ext_comb: combinational immediate / load-data extension with misaligned halfword flag.
module ext_comb
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int AW    = addr_w(OUT_W)
) (
  input  logic [OP_W-1:0]  op,
  input  logic [OUT_W-1:0] data,
  input  logic [AW-1:0]    addr_lo,
  output logic [OUT_W-1:0] res,
  output logic             err
);
  logic [IN_W-1:0]  imm;
  logic [7:0]       b;
  logic [15:0]      h;
  logic [OUT_W-1:0] sx;
  assign imm = data[IN_W-1:0];
  assign b   = 8'(data >> (8 * addr_lo));
  // a misaligned halfword still reads the aligned halfword containing it
  assign h   = 16'(data >> (16 * (addr_lo >> 1)));
  assign sx  = OUT_W'($signed(imm));
  always_comb begin
    res = '0;
    case (ext_op_e'(op))
      EXT_ZERO: res = OUT_W'(imm);
      EXT_SIGN: res = sx;
      EXT_LUI:  res = OUT_W'(imm) << (OUT_W - IN_W);
      EXT_BOFS: res = sx << 2;
      EXT_LB:   res = OUT_W'($signed(b));
      EXT_LBU:  res = OUT_W'(b);
      EXT_LH:   res = OUT_W'($signed(h));
      EXT_LHU:  res = OUT_W'(h);
      default:  res = '0;
    endcase
  end
  assign err = (op == EXT_LH || op == EXT_LHU) && addr_lo[0];
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered extender behind a valid/ready handshake with one skid entry.
module ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int OP_W  = ext_pkg::OP_W
) (
  input logic      clk,
  input logic      rst_n,
  ext_pipe_if.slave bus
);
  localparam int AW = ext_pkg::addr_w(OUT_W);
  typedef struct packed {
    logic             err;
    logic [OUT_W-1:0] data;
  } beat_t;
  logic [OUT_W-1:0] c_data;
  logic             c_err;
  beat_t            nxt, out_q, skid_q;
  logic             out_v, skid_full, rdy, accept, drain;
  ext_comb #(.IN_W(IN_W), .OUT_W(OUT_W), .AW(AW)) u_comb (
    .op(bus.in_op), .data(bus.in_data), .addr_lo(bus.in_addr_lo), .res(c_data), .err(c_err)
  );
  assign nxt    = '{err: c_err, data: c_data};
  assign accept = bus.in_valid && rdy;
  assign drain  = out_v && bus.out_ready;
  // ready is registered from skid occupancy so out_ready never reaches in_ready combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v     <= 1'b0;
      skid_full <= 1'b0;
      rdy       <= 1'b0;
      out_q     <= '0;
      skid_q    <= '0;
    end else if (bus.flush) begin
      out_v     <= 1'b0;
      skid_full <= 1'b0;
      rdy       <= 1'b1;
    end else begin
      rdy <= !skid_full;
      if (skid_full && drain) begin
        out_q     <= skid_q;
        skid_full <= 1'b0;
        rdy       <= 1'b1;
      end else if (accept && (!out_v || drain)) begin
        out_q <= nxt;
        out_v <= 1'b1;
      end else if (accept) begin
        skid_q    <= nxt;
        skid_full <= 1'b1;
        rdy       <= 1'b0;
      end else if (drain) begin
        out_v <= 1'b0;
      end
    end
  end
  assign bus.in_ready  = rdy;
  assign bus.out_valid = out_v;
  assign bus.out_data  = out_q.data;
  assign bus.out_err   = out_q.err;
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: directed and randomized checks of ext_pipe against a FIFO reference model.
module tb_ext_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ext_pipe_if #(.OUT_W(32), .OP_W(3)) bus ();
  ext_pipe #(.IN_W(16), .OUT_W(32), .OP_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  int checks = 0;
  int errors = 0;
  int drains = 0;
  int edges = 0;
  bit consumed = 1'b0;
  logic [32:0] q[$];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [32:0] model(logic [2:0] op, logic [31:0] d, logic [1:0] a);
    logic [31:0] imm, b, h, r;
    logic e;
    imm = d % 65536;
    b = (d >> (8 * a)) % 256;
    h = (d >> (16 * (a / 2))) % 65536;
    case (op)
      3'd0: r = imm;
      3'd1: r = imm < 32768 ? imm : imm - 65536;
      3'd2: r = imm * 65536;
      3'd3: r = (imm < 32768 ? imm : imm - 65536) * 4;
      3'd4: r = b < 128 ? b : b - 256;
      3'd5: r = b;
      3'd6: r = h < 32768 ? h : h - 65536;
      default: r = h;
    endcase
    e = op >= 6 && a % 2 == 1;
    return {e, r};
  endfunction
  always @(posedge clk or negedge rst_n) edges <= rst_n ? edges + 1 : 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      consumed = 1'b0;
    end else begin
      if (edges > 0) check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
      check("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
      if (bus.out_valid && q.size() != 0) check("out_beat", 64'({bus.out_err, bus.out_data}), 64'(q[0]));
      consumed = bus.in_valid && (bus.in_ready || bus.flush);
      if (bus.flush) q.delete();
      else begin
        if (bus.out_valid && bus.out_ready && q.size() != 0) begin
          void'(q.pop_front());
          drains++;
        end
        if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_op, bus.in_data, bus.in_addr_lo));
      end
    end
  end
  task automatic send(logic [2:0] op, logic [31:0] d, logic [1:0] a);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1; bus.in_op = op; bus.in_data = d; bus.in_addr_lo = a;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    check("send_accept", 64'(ok), 64'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic exp_beat(string tag, logic [2:0] op, logic [31:0] d, logic [1:0] a, logic [31:0] ed, logic ee);
    send(op, d, a);
    @(negedge clk);
    check({tag, "_v"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_d"}, 64'(bus.out_data), 64'(ed));
    check({tag, "_e"}, 64'(bus.out_err), 64'(ee));
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    int d0;
    bit ok;
    bus.flush = 0; bus.in_valid = 0; bus.in_op = 0; bus.in_data = 0; bus.in_addr_lo = 0; bus.out_ready = 1;
    #12;
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_data", 64'(bus.out_data), 64'd0);
    check("rst_err", 64'(bus.out_err), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_ready", 64'(bus.in_ready), 64'd1);
    exp_beat("zero", 3'd0, 32'h0000011c, 2'd0, 32'h0000011c, 1'b0);
    exp_beat("zero_hi", 3'd0, 32'hdead8001, 2'd3, 32'h00008001, 1'b0);
    exp_beat("sign", 3'd1, 32'h000082ca, 2'd0, 32'hffff82ca, 1'b0);
    exp_beat("lui", 3'd2, 32'h0000729e, 2'd0, 32'h729e0000, 1'b0);
    exp_beat("bofs_neg", 3'd3, 32'h00008000, 2'd0, 32'hfffe0000, 1'b0);
    exp_beat("bofs_pos", 3'd3, 32'h00000004, 2'd0, 32'h00000010, 1'b0);
    exp_beat("lb", 3'd4, 32'h12845678, 2'd2, 32'hffffff84, 1'b0);
    exp_beat("lbu", 3'd5, 32'h12845678, 2'd2, 32'h00000084, 1'b0);
    exp_beat("lb3", 3'd4, 32'h12845678, 2'd3, 32'h00000012, 1'b0);
    exp_beat("lh", 3'd6, 32'h12845678, 2'd2, 32'h00001284, 1'b0);
    exp_beat("lhu", 3'd7, 32'h12845678, 2'd0, 32'h00005678, 1'b0);
    exp_beat("lh_mis", 3'd6, 32'h12845678, 2'd1, 32'h00005678, 1'b1);
    exp_beat("lhu_mis", 3'd7, 32'hf2845678, 2'd3, 32'h0000f284, 1'b1);
    // backpressure: two beats fill output and skid, the third must wait
    @(negedge clk);
    d0 = drains;
    bus.out_ready = 0;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_op = 3'd1; bus.in_data = 1; bus.in_addr_lo = 0;
    @(negedge clk); check("bp_rdy1", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 bus.in_data = 2;
    @(negedge clk); check("bp_rdy2", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 bus.in_data = 3;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", 64'(bus.in_ready), 64'd0);
      check("bp_hold", 64'(bus.out_data), 64'd1);
    end
    @(posedge clk); #1 bus.out_ready = 1;
    @(negedge clk); check("bp_rdy_lag", 64'(bus.in_ready), 64'd0);
    @(negedge clk); check("bp_rdy_back", 64'(bus.in_ready), 64'd1);
    check("bp_out2", 64'(bus.out_data), 64'd2);
    @(posedge clk); #1 bus.in_valid = 0;
    @(negedge clk); check("bp_out3", 64'(bus.out_data), 64'd3);
    repeat (3) @(negedge clk);
    check("bp_count", 64'(drains - d0), 64'd3);
    // flush with both entries held, then flush dropping a presented beat
    bus.out_ready = 0;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_op = 3'd0; bus.in_data = 32'h55;
    @(posedge clk); #1 bus.in_data = 32'h66;
    @(posedge clk); #1 bus.in_data = 32'h77;
    @(negedge clk);
    check("fl_full", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1 bus.flush = 1;
    @(posedge clk); #1 bus.flush = 0; bus.in_valid = 0;
    @(negedge clk);
    check("fl_valid", 64'(bus.out_valid), 64'd0);
    check("fl_rdy", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1 bus.in_valid = 1; bus.in_data = 32'h99; bus.flush = 1;
    @(posedge clk); #1 bus.in_valid = 0; bus.flush = 0;
    @(negedge clk);
    check("fl_drop", 64'(bus.out_valid), 64'd0);
    bus.out_ready = 1;
    exp_beat("fl_first", 3'd0, 32'h00000001, 2'd0, 32'h00000001, 1'b0);
    // randomized traffic checked by the scoreboard
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (consumed || !bus.in_valid) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_op = 3'($urandom_range(0, 7));
        bus.in_data = $urandom;
        bus.in_addr_lo = 2'($urandom_range(0, 3));
      end
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.flush = ($urandom_range(0, 39) == 0);
    end
    @(posedge clk); #1 bus.in_valid = 0; bus.flush = 0; bus.out_ready = 1;
    repeat (4) @(negedge clk);
    check("rnd_empty", 64'(q.size()), 64'd0);
    // asynchronous reset with both entries held
    bus.out_ready = 0;
    @(posedge clk); #1;
    bus.in_valid = 1; bus.in_op = 3'd0; bus.in_data = 32'h5;
    @(posedge clk); #1 bus.in_data = 32'h6;
    @(posedge clk); #1 bus.in_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(bus.out_valid), 64'd0);
    check("ar_data", 64'(bus.out_data), 64'd0);
    check("ar_rdy", 64'(bus.in_ready), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    bus.out_ready = 1;
    ok = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    check("ar_stale", 64'(ok), 64'd0);
    exp_beat("ar_next", 3'd2, 32'h00000001, 2'd0, 32'h00010000, 1'b0);
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
